led_mem_arbiter: RTL and testbench
==================================

Name: led_mem_arbiter

Overview:
- Shares one single-port frame-buffer RAM (8-bit words) between NUM_REQ LED strip drivers and one host write port.
- Each strip driver issues single-cycle read strobes with an address. The arbiter queues one read per driver, grants RAM cycles round-robin, and returns the data through a held per-driver data register plus a valid pulse.
- Host writes (frame updates) are interleaved with bounded wait. Sits between the strip-driver array and the frame RAM.

Parameters:
- NUM_REQ, 4: number of strip-driver read requesters.
- ADDRESS_WIDTH, 13: RAM address width.
- DATA_WIDTH, 8: RAM word width.
- MEM_LATENCY, 1: cycles from ram_re high to ram_rdata valid (1..3).
- WRITE_MAX_WAIT, 8: cycles a pending write may be deferred by reads before it is forced.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-high.
- req_addr  in  NUM_REQ*ADDRESS_WIDTH  per-driver read address; slice i = [i*AW +: AW].
- req_read_enable  in  NUM_REQ  per-driver read strobe (level sampled each clk).
- req_data  out  NUM_REQ*DATA_WIDTH  per-driver returned data, held until that driver's next return.
- req_data_valid  out  NUM_REQ  one-cycle pulse when req_data slice i updates.
- wr_addr  in  ADDRESS_WIDTH  host write address.
- wr_data  in  DATA_WIDTH  host write data.
- wr_valid  in  1  host write request.
- wr_ready  out  1  write holding register empty; transfer occurs when wr_valid && wr_ready.
- ram_addr  out  ADDRESS_WIDTH  RAM address (registered).
- ram_wdata  out  DATA_WIDTH  RAM write data (registered).
- ram_we  out  1  RAM write enable (registered).
- ram_re  out  1  RAM read enable (registered).
- ram_rdata  in  DATA_WIDTH  RAM read data.

Behaviour:
- Reset values:
  - All outputs 0, except wr_ready=1.
  - Pending bits, write-holding register, wait counter, return tags and RR pointer (=0) all cleared.
  - Any in-flight RAM read is discarded; no req_data_valid is emitted for it.
- Read capture:
  - If req_read_enable[i]=1 at an edge, set pend[i] and latch addr[i] from req_addr.
  - A strobe arriving while pend[i] is already set overwrites addr[i]. The request count stays 1.
- Write capture: when wr_valid && wr_ready, latch wr_addr/wr_data and set wpend. wr_ready = ~wpend.
- Issue: at most one RAM op per cycle; every RAM output is registered.
  - Write first when wpend && (pend==0 || wait_cnt >= WRITE_MAX_WAIT). This drives ram_we=1, ram_addr=waddr, ram_wdata=wdata for one cycle, clears wpend and resets wait_cnt to 0.
  - Otherwise, if pend!=0, grant the first set bit at or after rr_ptr, wrapping modulo NUM_REQ. This drives ram_re=1 and ram_addr=addr[g] for one cycle, clears pend[g] and sets rr_ptr=(g+1) mod NUM_REQ.
  - wait_cnt increments (saturating) on every cycle wpend=1 and a read is issued.
  - Otherwise ram_re=ram_we=0.
- Same-edge grant and new strobe for the same i: the set wins. pend[i] stays 1 with the new addr.
- Return path: a tag shift register of depth MEM_LATENCY carries {valid, g}. When the tag exits, req_data slice g <= ram_rdata and req_data_valid[g]=1 for exactly one cycle.
- Latency, with the strobe high in cycle c:
  - Best case: ram_re high in cycle c+1; req_data_valid high in cycle c+1+MEM_LATENCY+1 (c+3 at default).
  - Worst case adds NUM_REQ-1 reads plus one forced write: c+NUM_REQ+2+MEM_LATENCY.
- Drivers on this arbiter sample on req_data_valid, not at a fixed offset.
- Addresses are passed through unchecked; no range clamping.
- Host write to an address with a pending read: RAM order is issue order, and the read returns whichever op reached RAM first.

Decomposition:
- Package led_mem_pkg: DATA_WIDTH and ADDRESS_WIDTH defaults, the tag struct {valid, idx}, and the clog2-derived index width.
- Sub-module rr_arbiter: NUM_REQ-wide round-robin picker with a registered pointer. Inputs are the request vector and an advance strobe; outputs are the one-hot grant and the index.

Test Plan:
- Single read: driver 0 strobes addr 0x005 with RAM[5]=0xA7 → ram_re cycle c+1 with ram_addr=0x005; req_data[0]=0xA7 and req_data_valid[0] pulse in cycle c+3; other valids stay 0.
- Contention: drivers 0..3 strobe addrs 0x10..0x13 in the same cycle → ram_re on 4 consecutive cycles in order 0,1,2,3; rr_ptr=0 afterward. Repeating the burst with rr_ptr preset to 2 gives order 2,3,0,1.
- Write starvation bound: keep all drivers re-strobing every cycle and write addr 0x20=0x55 → ram_we asserted within WRITE_MAX_WAIT+1=9 cycles of acceptance; a later read of 0x20 returns 0x55.
- Overwrite/simultaneity: driver 1 strobes 0x30, then strobes 0x31 before its grant → exactly one ram_re for driver 1 with addr 0x31 and one valid pulse. A strobe on the grant edge yields a second read.
- Back-pressure: two wr_valid beats with no gap → wr_ready drops after the first beat and the second beat transfers only after the first write issues.
- Reset mid-operation: assert rst the cycle after ram_re → no req_data_valid pulses, pend clear, and wr_ready=1 on the first post-reset cycle.

Source files
------------

// File: rtl/led_mem_pkg.sv
// Shared types for the LED frame-buffer arbiter: default widths and the return tag.
package led_mem_pkg;
  localparam int NUM_REQ_DEF       = 4;
  localparam int ADDRESS_WIDTH_DEF = 13;
  localparam int DATA_WIDTH_DEF    = 8;
  localparam int IDX_W = (NUM_REQ_DEF > 1) ? $clog2(NUM_REQ_DEF) : 1;

  typedef struct packed {
    logic             valid;
    logic [IDX_W-1:0] idx;
  } tag_t;
endpackage

// File: rtl/led_mem_arbiter_rr_arbiter.sv
// Round-robin picker: first request at or after the pointer; pointer moves past the winner on advance.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [N-1:0]  req,
  input  logic          advance,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx
);
  logic [IW-1:0] ptr;

  // Scan from the farthest slot back toward ptr so the nearest request wins.
  always_comb begin
    int j;
    j     = 0;
    grant = '0;
    idx   = '0;
    for (int k = N-1; k >= 0; k--) begin
      j = (int'(ptr) + k) % N;
      if (req[j]) begin
        grant    = '0;
        grant[j] = 1'b1;
        idx      = IW'(j);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst)
      ptr <= '0;
    else if (advance)
      ptr <= (int'(idx) == N-1) ? '0 : idx + IW'(1);
  end
endmodule

// File: rtl/led_mem_arbiter.sv
// Shares one single-port frame RAM between NUM_REQ strip-driver readers and a host writer.
module led_mem_arbiter import led_mem_pkg::*; #(
  parameter int NUM_REQ        = NUM_REQ_DEF,
  parameter int ADDRESS_WIDTH  = ADDRESS_WIDTH_DEF,
  parameter int DATA_WIDTH     = DATA_WIDTH_DEF,
  parameter int MEM_LATENCY    = 1,
  parameter int WRITE_MAX_WAIT = 8
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NUM_REQ*ADDRESS_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ-1:0]               req_read_enable,
  output logic [NUM_REQ*DATA_WIDTH-1:0]    req_data,
  output logic [NUM_REQ-1:0]               req_data_valid,
  input  logic [ADDRESS_WIDTH-1:0]         wr_addr,
  input  logic [DATA_WIDTH-1:0]            wr_data,
  input  logic                             wr_valid,
  output logic                             wr_ready,
  output logic [ADDRESS_WIDTH-1:0]         ram_addr,
  output logic [DATA_WIDTH-1:0]            ram_wdata,
  output logic                             ram_we,
  output logic                             ram_re,
  input  logic [DATA_WIDTH-1:0]            ram_rdata
);
  localparam int WW = $clog2(WRITE_MAX_WAIT + 1);

  logic [NUM_REQ-1:0]                    pend;
  logic [NUM_REQ-1:0][ADDRESS_WIDTH-1:0] addr;
  logic                                  wpend;
  logic [ADDRESS_WIDTH-1:0]              waddr;
  logic [DATA_WIDTH-1:0]                 wdata;
  logic [WW-1:0]                         wait_cnt;
  tag_t [MEM_LATENCY:0]                  tag_pipe;
  logic [NUM_REQ-1:0]                    grant;
  logic [IDX_W-1:0]                      gidx;
  logic                                  do_write, do_read;

  // A write goes whenever the readers are idle, or once it has been passed over long enough.
  assign do_write = wpend && ((pend == '0) || (wait_cnt >= WW'(WRITE_MAX_WAIT)));
  assign do_read  = !do_write && (pend != '0);
  assign wr_ready = ~wpend;

  rr_arbiter #(.N(NUM_REQ), .IW(IDX_W)) u_rr (
    .clk     (clk),
    .rst     (rst),
    .req     (pend),
    .advance (do_read),
    .grant   (grant),
    .idx     (gidx)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      pend           <= '0;
      addr           <= '0;
      wpend          <= 1'b0;
      waddr          <= '0;
      wdata          <= '0;
      wait_cnt       <= '0;
      ram_addr       <= '0;
      ram_wdata      <= '0;
      ram_we         <= 1'b0;
      ram_re         <= 1'b0;
      tag_pipe       <= '0;
      req_data       <= '0;
      req_data_valid <= '0;
    end else begin
      ram_we <= do_write;
      ram_re <= do_read;
      if (do_write) begin
        ram_addr  <= waddr;
        ram_wdata <= wdata;
        wpend     <= 1'b0;
        wait_cnt  <= '0;
      end else if (do_read) begin
        ram_addr <= addr[gidx];
        if (wpend && (wait_cnt < WW'(WRITE_MAX_WAIT)))
          wait_cnt <= wait_cnt + WW'(1);
      end
      if (wr_valid && !wpend) begin
        wpend <= 1'b1;
        waddr <= wr_addr;
        wdata <= wr_data;
      end

      // A strobe on the grant edge re-arms the slot with the new address.
      pend <= (pend & ~({NUM_REQ{do_read}} & grant)) | req_read_enable;
      for (int i = 0; i < NUM_REQ; i++)
        if (req_read_enable[i])
          addr[i] <= req_addr[i*ADDRESS_WIDTH +: ADDRESS_WIDTH];

      tag_pipe[0].valid <= do_read;
      tag_pipe[0].idx   <= gidx;
      for (int s = 1; s <= MEM_LATENCY; s++)
        tag_pipe[s] <= tag_pipe[s-1];

      req_data_valid <= '0;
      if (tag_pipe[MEM_LATENCY].valid) begin
        req_data_valid[tag_pipe[MEM_LATENCY].idx] <= 1'b1;
        req_data[int'(tag_pipe[MEM_LATENCY].idx)*DATA_WIDTH +: DATA_WIDTH] <= ram_rdata;
      end
    end
  end
endmodule

// File: tb/tb_led_mem_arbiter.sv
// Bench for led_mem_arbiter: directed scenarios plus random traffic against a transaction-level model.
module tb_led_mem_arbiter;
  localparam int N = 4, AW = 13, DW = 8, L = 1, WMAX = 8;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [N*AW-1:0] req_addr = '0;
  logic [N-1:0]    req_read_enable = '0;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]    req_data_valid;
  logic [AW-1:0]   wr_addr = '0;
  logic [DW-1:0]   wr_data = '0;
  logic            wr_valid = 1'b0;
  logic            wr_ready;
  logic [AW-1:0]   ram_addr;
  logic [DW-1:0]   ram_wdata, ram_rdata;
  logic            ram_we, ram_re;
  logic            mem_init = 1'b1;

  int n_checks = 0, n_fail = 0;

  always #5 clk = ~clk;

  led_mem_arbiter #(.NUM_REQ(N), .ADDRESS_WIDTH(AW), .DATA_WIDTH(DW),
                    .MEM_LATENCY(L), .WRITE_MAX_WAIT(WMAX)) dut (
    .clk(clk), .rst(rst), .req_addr(req_addr), .req_read_enable(req_read_enable),
    .req_data(req_data), .req_data_valid(req_data_valid),
    .wr_addr(wr_addr), .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_we(ram_we), .ram_re(ram_re),
    .ram_rdata(ram_rdata));

  function automatic logic [DW-1:0] pat(int a);
    if (a == 5) return 8'hA7;
    return 8'((a * 37 + 11) ^ (a >> 8));
  endfunction

  // Frame RAM with one cycle of read latency.
  logic [DW-1:0] ram_mem [1<<AW];
  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < (1<<AW); i++) ram_mem[i] <= pat(i);
    end else begin
      if (ram_we) ram_mem[ram_addr] <= ram_wdata;
      if (ram_re) ram_rdata <= ram_mem[ram_addr];
    end
  end

  // Reference model: pending slots, write holding slot, and a queue of dated returns.
  typedef struct { int due; int idx; logic [DW-1:0] data; } ret_t;
  ret_t          retq[$];
  bit            m_pend[N];
  logic [AW-1:0] m_addr[N];
  bit            m_wpend;
  logic [AW-1:0] m_waddr;
  logic [DW-1:0] m_wdata;
  int            m_wait, m_ptr, tnow;
  logic [DW-1:0] model_mem [1<<AW];
  bit            exp_re, exp_we;
  logic [AW-1:0] exp_addr;
  logic [DW-1:0] exp_wdata;
  bit            exp_valid[N];
  logic [DW-1:0] exp_data[N];

  task automatic tick();
    bit any, rdy_old;
    int g;
    tnow++;
    if (rst) begin
      for (int i = 0; i < N; i++) begin
        m_pend[i] = 0; m_addr[i] = '0; exp_valid[i] = 0; exp_data[i] = '0;
      end
      m_wpend = 0; m_wait = 0; m_ptr = 0; exp_re = 0; exp_we = 0;
      retq.delete();
    end else begin
      for (int i = 0; i < N; i++) exp_valid[i] = 0;
      while (retq.size() > 0 && retq[0].due == tnow) begin
        exp_valid[retq[0].idx] = 1;
        exp_data[retq[0].idx]  = retq[0].data;
        void'(retq.pop_front());
      end
      any = 0;
      for (int i = 0; i < N; i++) if (m_pend[i]) any = 1;
      rdy_old = !m_wpend;
      exp_re = 0; exp_we = 0;
      if (m_wpend && (!any || m_wait >= WMAX)) begin
        exp_we = 1; exp_addr = m_waddr; exp_wdata = m_wdata;
        model_mem[m_waddr] = m_wdata;
        m_wpend = 0; m_wait = 0;
      end else if (any) begin
        g = -1;
        for (int k = 0; k < N; k++)
          if (g < 0 && m_pend[(m_ptr + k) % N]) g = (m_ptr + k) % N;
        exp_re = 1; exp_addr = m_addr[g];
        retq.push_back('{due: tnow + L + 1, idx: g, data: model_mem[m_addr[g]]});
        m_pend[g] = 0;
        m_ptr = (g + 1) % N;
        if (m_wpend && m_wait < WMAX) m_wait++;
      end
      for (int i = 0; i < N; i++)
        if (req_read_enable[i]) begin m_pend[i] = 1; m_addr[i] = req_addr[i*AW +: AW]; end
      if (wr_valid && rdy_old) begin m_wpend = 1; m_waddr = wr_addr; m_wdata = wr_data; end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1; mem_init = 1;
    tick(); mem_init = 0;
    tick(); tick();
    n_checks++; if (ram_re !== 1'b0 || ram_we !== 1'b0) begin n_fail++; $display("FAIL reset_ram_en: re=%b we=%b want 0 0", ram_re, ram_we); end
    n_checks++; if (ram_addr !== '0 || ram_wdata !== '0) begin n_fail++; $display("FAIL reset_ram_bus: addr=%h wdata=%h want 0", ram_addr, ram_wdata); end
    n_checks++; if (req_data !== '0) begin n_fail++; $display("FAIL reset_req_data: got %h want 0", req_data); end
    n_checks++; if (req_data_valid !== '0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", req_data_valid); end
    n_checks++; if (wr_ready !== 1'b1) begin n_fail++; $display("FAIL reset_wr_ready: got %b want 1", wr_ready); end
    rst = 0;
    tick();
  endtask

  task automatic burst_order(input string nm, input int first);
    for (int i = 0; i < N; i++) req_addr[i*AW +: AW] = AW'(16 + i);
    req_read_enable = '1;
    tick();
    req_read_enable = '0;
    n_checks++; if (ram_re !== 1'b0) begin n_fail++; $display("FAIL %s_capture_re: got %b want 0", nm, ram_re); end
    for (int k = 0; k < N; k++) begin
      tick();
      n_checks++;
      if (ram_re !== 1'b1 || ram_addr !== AW'(16 + (first + k) % N)) begin
        n_fail++; $display("FAIL %s_order[%0d]: re=%b addr=%h want 1 %h", nm, k, ram_re, ram_addr, 16 + (first + k) % N);
      end
    end
    tick();
    n_checks++; if (ram_re !== 1'b0) begin n_fail++; $display("FAIL %s_idle_re: got %b want 0", nm, ram_re); end
    repeat (3) tick();
    for (int i = 0; i < N; i++) begin
      n_checks++;
      if (req_data[i*DW +: DW] !== pat(16 + i)) begin n_fail++; $display("FAIL %s_data[%0d]: got %h want %h", nm, i, req_data[i*DW +: DW], pat(16 + i)); end
    end
  endtask

  task automatic test_contention();
    burst_order("burst_p0", 0);
    req_addr[1*AW +: AW] = AW'('h14);
    req_read_enable = 4'b0010;
    tick();
    req_read_enable = '0;
    tick();
    n_checks++; if (ram_re !== 1'b1 || ram_addr !== AW'('h14)) begin n_fail++; $display("FAIL preset_read: re=%b addr=%h want 1 014", ram_re, ram_addr); end
    repeat (3) tick();
    burst_order("burst_p2", 2);
  endtask

  task automatic test_overwrite();
    int c30, c31, c32, c33, v1;
    c30 = 0; c31 = 0; c32 = 0; c33 = 0; v1 = 0;
    req_addr[1*AW +: AW] = AW'('h30); req_addr[2*AW +: AW] = AW'('h50);
    req_read_enable = 4'b0110;
    tick();
    req_addr[1*AW +: AW] = AW'('h31);
    req_read_enable = 4'b0010;
    for (int k = 0; k < 9; k++) begin
      tick();
      req_read_enable = '0;
      if (ram_re && ram_addr == AW'('h30)) c30++;
      if (ram_re && ram_addr == AW'('h31)) c31++;
      if (req_data_valid[1]) v1++;
    end
    n_checks++; if (c30 != 0 || c31 != 1) begin n_fail++; $display("FAIL overwrite_reads: 0x30 x%0d 0x31 x%0d want 0 1", c30, c31); end
    n_checks++; if (v1 != 1) begin n_fail++; $display("FAIL overwrite_pulses: got %0d want 1", v1); end
    n_checks++; if (req_data[1*DW +: DW] !== pat('h31)) begin n_fail++; $display("FAIL overwrite_data: got %h want %h", req_data[1*DW +: DW], pat('h31)); end
    v1 = 0;
    req_addr[1*AW +: AW] = AW'('h32);
    req_read_enable = 4'b0010;
    tick();
    req_addr[1*AW +: AW] = AW'('h33);
    for (int k = 0; k < 9; k++) begin
      tick();
      req_read_enable = '0;
      if (ram_re && ram_addr == AW'('h32)) c32++;
      if (ram_re && ram_addr == AW'('h33)) c33++;
      if (req_data_valid[1]) v1++;
    end
    n_checks++; if (c32 != 1 || c33 != 1) begin n_fail++; $display("FAIL grant_edge_reads: 0x32 x%0d 0x33 x%0d want 1 1", c32, c33); end
    n_checks++; if (v1 != 2) begin n_fail++; $display("FAIL grant_edge_pulses: got %0d want 2", v1); end
    n_checks++; if (req_data[1*DW +: DW] !== pat('h33)) begin n_fail++; $display("FAIL grant_edge_data: got %h want %h", req_data[1*DW +: DW], pat('h33)); end
  endtask

  task automatic test_single_read();
    req_addr[0 +: AW] = AW'(5);
    req_read_enable = 4'b0001;
    tick();
    req_read_enable = '0;
    n_checks++; if (ram_re !== 1'b0) begin n_fail++; $display("FAIL single_early_re: got %b want 0", ram_re); end
    tick();
    n_checks++; if (ram_re !== 1'b1 || ram_addr !== AW'(5)) begin n_fail++; $display("FAIL single_issue: re=%b addr=%h want 1 005", ram_re, ram_addr); end
    tick();
    n_checks++; if (req_data_valid !== 4'b0000) begin n_fail++; $display("FAIL single_early_valid: got %b want 0000", req_data_valid); end
    tick();
    n_checks++; if (req_data_valid !== 4'b0001) begin n_fail++; $display("FAIL single_valid: got %b want 0001", req_data_valid); end
    n_checks++; if (req_data[0 +: DW] !== 8'hA7) begin n_fail++; $display("FAIL single_data: got %h want a7", req_data[0 +: DW]); end
    tick();
    n_checks++; if (req_data_valid !== 4'b0000 || req_data[0 +: DW] !== 8'hA7) begin n_fail++; $display("FAIL single_pulse_hold: valid=%b data=%h want 0000 a7", req_data_valid, req_data[0 +: DW]); end
  endtask

  task automatic test_write_starvation();
    int n;
    bit seen;
    for (int i = 0; i < N; i++) req_addr[i*AW +: AW] = AW'('h40 + i);
    req_read_enable = '1;
    repeat (3) tick();
    n_checks++; if (wr_ready !== 1'b1) begin n_fail++; $display("FAIL starve_ready: got %b want 1", wr_ready); end
    wr_addr = AW'('h20); wr_data = 8'h55; wr_valid = 1;
    tick();
    wr_valid = 0;
    n = 0; seen = 0;
    while (!seen && n < 20) begin tick(); n++; seen = ram_we; end
    n_checks++; if (!seen || n != WMAX + 1) begin n_fail++; $display("FAIL starve_bound: write after %0d cycles (seen=%b) want %0d", n, seen, WMAX + 1); end
    n_checks++; if (ram_addr !== AW'('h20) || ram_wdata !== 8'h55) begin n_fail++; $display("FAIL starve_write: addr=%h data=%h want 020 55", ram_addr, ram_wdata); end
    req_read_enable = '0;
    repeat (10) tick();
    req_addr[2*AW +: AW] = AW'('h20);
    req_read_enable = 4'b0100;
    tick();
    req_read_enable = '0;
    n = 0; seen = 0;
    while (!seen && n < 10) begin tick(); n++; seen = req_data_valid[2]; end
    n_checks++; if (!seen || req_data[2*DW +: DW] !== 8'h55) begin n_fail++; $display("FAIL starve_readback: seen=%b data=%h want 1 55", seen, req_data[2*DW +: DW]); end
  endtask

  task automatic test_back_pressure();
    wr_addr = AW'('h60); wr_data = 8'h11; wr_valid = 1;
    tick();
    n_checks++; if (wr_ready !== 1'b0) begin n_fail++; $display("FAIL bp_ready_drop: got %b want 0", wr_ready); end
    wr_addr = AW'('h61); wr_data = 8'h22;
    tick();
    n_checks++; if (ram_we !== 1'b1 || ram_addr !== AW'('h60) || ram_wdata !== 8'h11) begin n_fail++; $display("FAIL bp_first: we=%b addr=%h data=%h want 1 060 11", ram_we, ram_addr, ram_wdata); end
    n_checks++; if (wr_ready !== 1'b1) begin n_fail++; $display("FAIL bp_ready_back: got %b want 1", wr_ready); end
    tick();
    wr_valid = 0;
    n_checks++; if (ram_we !== 1'b0 || wr_ready !== 1'b0) begin n_fail++; $display("FAIL bp_second_accept: we=%b ready=%b want 0 0", ram_we, wr_ready); end
    tick();
    n_checks++; if (ram_we !== 1'b1 || ram_addr !== AW'('h61) || ram_wdata !== 8'h22) begin n_fail++; $display("FAIL bp_second: we=%b addr=%h data=%h want 1 061 22", ram_we, ram_addr, ram_wdata); end
    tick();
  endtask

  task automatic test_reset_mid();
    req_addr[2*AW +: AW] = AW'(7);
    req_read_enable = 4'b0100;
    wr_addr = AW'('h70); wr_data = 8'h99; wr_valid = 1;
    tick();
    req_read_enable = '0; wr_valid = 0;
    tick();
    n_checks++; if (ram_re !== 1'b1 || wr_ready !== 1'b0) begin n_fail++; $display("FAIL mid_pre: re=%b ready=%b want 1 0", ram_re, wr_ready); end
    rst = 1;
    tick();
    rst = 0;
    n_checks++; if (wr_ready !== 1'b1 || ram_re !== 1'b0 || ram_we !== 1'b0) begin n_fail++; $display("FAIL mid_reset_out: ready=%b re=%b we=%b want 1 0 0", wr_ready, ram_re, ram_we); end
    for (int k = 0; k < 5; k++) begin
      tick();
      n_checks++;
      if (req_data_valid !== '0 || ram_re !== 1'b0 || ram_we !== 1'b0) begin
        n_fail++; $display("FAIL mid_quiet[%0d]: valid=%b re=%b we=%b want 0", k, req_data_valid, ram_re, ram_we);
      end
    end
  endtask

  task automatic test_random();
    logic [N-1:0] ev;
    for (int t = 0; t < 800; t++) begin
      rst = ($urandom_range(0, 199) == 0);
      for (int i = 0; i < N; i++) begin
        req_read_enable[i]    = ($urandom_range(0, 99) < 30);
        req_addr[i*AW +: AW]  = AW'($urandom_range(0, 63));
      end
      wr_valid = ($urandom_range(0, 99) < 40);
      wr_addr  = AW'($urandom_range(0, 63));
      wr_data  = DW'($urandom);
      tick();
      for (int i = 0; i < N; i++) ev[i] = exp_valid[i];
      n_checks++; if (ram_re !== exp_re || ram_we !== exp_we) begin n_fail++; $display("FAIL rnd_op[%0d]: re=%b we=%b want %b %b", t, ram_re, ram_we, exp_re, exp_we); end
      if (exp_re || exp_we) begin
        n_checks++; if (ram_addr !== exp_addr) begin n_fail++; $display("FAIL rnd_addr[%0d]: got %h want %h", t, ram_addr, exp_addr); end
      end
      if (exp_we) begin
        n_checks++; if (ram_wdata !== exp_wdata) begin n_fail++; $display("FAIL rnd_wdata[%0d]: got %h want %h", t, ram_wdata, exp_wdata); end
      end
      n_checks++; if (req_data_valid !== ev) begin n_fail++; $display("FAIL rnd_valid[%0d]: got %b want %b", t, req_data_valid, ev); end
      for (int i = 0; i < N; i++) begin
        n_checks++;
        if (req_data[i*DW +: DW] !== exp_data[i]) begin n_fail++; $display("FAIL rnd_data[%0d][%0d]: got %h want %h", t, i, req_data[i*DW +: DW], exp_data[i]); end
      end
      n_checks++; if (wr_ready !== !m_wpend) begin n_fail++; $display("FAIL rnd_wr_ready[%0d]: got %b want %b", t, wr_ready, !m_wpend); end
    end
    rst = 0; req_read_enable = '0; wr_valid = 0;
    repeat (4) tick();
  endtask

  initial begin
    tnow = 0;
    for (int i = 0; i < (1<<AW); i++) model_mem[i] = pat(i);
    test_reset();
    test_contention();
    test_overwrite();
    test_single_read();
    test_write_starvation();
    test_back_pressure();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
